// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control sequencer for the multi-cycle RV32I datapath (shared ALU, unified
//   memory). Steps each instruction through IF/ID/EX/MEM/WB plus the BR, JMP,
//   PC4 and HALT states, and drives every datapath select and write enable.
//   Outputs are combinational from state, opcode and inputs; state is
//   registered with an asynchronous active-high reset.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   opcode                IR[6:0], valid from ID onward
//   mem_ready             memory finished the current access this cycle
//   alu_bcond             branch condition from the ALU (BR only)
//   halt_req              ecall terminate condition (x17 == 10)
//   pc_write/pc_source    PC load and source (0 ALU result, 1 ALUOut)
//   ir_write, mdr_write   IR / MDR load
//   i_or_d                memory address (0 PC, 1 ALUOut)
//   mem_read, mem_write   memory requests
//   reg_write, wb_sel     register write and rd source (00 ALUOut, 01 MDR, 10 ALU)
//   alu_src_a/b, alu_op_sel  ALU operand and operation selects
//   is_ecall, is_halted   ecall in decode, sticky halt
//   state                 current state (debug)
//   mem_timeout           memory watchdog fired (sticky)
//
// Optional feature: define MC_CTRL_TIMEOUT_EN to enable a watchdog that halts
// after TIMEOUT_CYCLES consecutive wait cycles in IF/MEM. Without it the
// sequencer waits indefinitely and mem_timeout is tied low.

module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STATE_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  input  logic               alu_bcond,
  input  logic               halt_req,
  output logic               pc_write,
  output logic               pc_source,
  output logic               ir_write,
  output logic               mdr_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op_sel,
  output logic               is_ecall,
  output logic               is_halted,
  output logic [STATE_W-1:0] state,
  output logic               mem_timeout
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_IF   = STATE_W'(0),
    S_ID   = STATE_W'(1),
    S_EX   = STATE_W'(2),
    S_MEM  = STATE_W'(3),
    S_WB   = STATE_W'(4),
    S_BR   = STATE_W'(5),
    S_JMP  = STATE_W'(6),
    S_PC4  = STATE_W'(7),
    S_HALT = STATE_W'(8)
  } state_t;

  state_t state_q, state_d;
  logic   timeout_hit;

  assign state = state_q;

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  logic             waiting;

  assign waiting     = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready;
  // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
  assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_timeout = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (waiting && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      else                         wait_cnt <= '0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op_sel = ALU_ADD;
    is_ecall   = 1'b0;
    is_halted  = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        // Speculatively compute PC+imm into ALUOut for BR/JMP.
        alu_src_b = 2'b10;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR: state_d = S_EX;
          OP_BR:  state_d = S_BR;
          OP_JAL: state_d = S_JMP;
          OP_SYS: begin
            is_ecall = 1'b1;
            if (halt_req) begin
              state_d = S_HALT;
            end else begin
              alu_src_b = 2'b01;
              pc_write  = 1'b1;
              state_d   = S_IF;
            end
          end
          default: state_d = S_PC4;
        endcase
      end
      S_EX: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_R: begin
            alu_src_b  = 2'b00;
            alu_op_sel = ALU_FUNCT;
            state_d    = S_WB;
          end
          OP_I: begin
            alu_src_b  = 2'b10;
            alu_op_sel = ALU_FUNCT;
            state_d    = S_WB;
          end
          OP_JALR: begin
            alu_src_b = 2'b10;
            state_d   = S_JMP;
          end
          default: begin
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
          if (mem_ready) begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
            state_d   = S_IF;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_BR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b00;
        alu_op_sel = ALU_BR;
        if (alu_bcond) begin
          pc_write  = 1'b1;
          pc_source = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_PC4;
        end
      end
      S_JMP: begin
        alu_src_b = 2'b01;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_source = 1'b1;
        state_d   = S_IF;
      end
      S_PC4: begin
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_HALT: begin
        is_halted = 1'b1;
      end
      default: state_d = S_IF;
    endcase

    if (timeout_hit) state_d = S_HALT;

    // Reset masks every write/request enable combinationally.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int unsigned TB_TO = 4;
`else
  localparam int unsigned TB_TO = 255;
`endif

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       alu_bcond = 1'b0;
  logic       halt_req = 1'b0;
  logic       pc_write, pc_source, ir_write, mdr_write, i_or_d;
  logic       mem_read, mem_write, reg_write;
  logic [1:0] wb_sel, alu_src_b, alu_op_sel;
  logic       alu_src_a, is_ecall, is_halted, mem_timeout;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(TB_TO), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .alu_bcond(alu_bcond), .halt_req(halt_req), .pc_write(pc_write),
    .pc_source(pc_source), .ir_write(ir_write), .mdr_write(mdr_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel), .is_ecall(is_ecall),
    .is_halted(is_halted), .state(state), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Leaves the bench at a falling edge, shortly after reset release, in IF.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    #1;
    checks++;
    if (state !== 4'd0 || is_halted !== 1'b0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got state=%0d halted=%b to=%b want 0/0/0", state, is_halted, mem_timeout);
    end
    checks++;
    if ({pc_write, ir_write, mdr_write, mem_read, mem_write, reg_write} !== 6'b0) begin
      errors++;
      $display("FAIL reset_enables got %b want 000000",
               {pc_write, ir_write, mdr_write, mem_read, mem_write, reg_write});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    int s[$] = '{0, 1, 2, 4, 0};
    opcode = OP_R; mem_ready = 1'b1; alu_bcond = 1'b0; halt_req = 1'b0;
    foreach (s[i]) begin
      #1;
      checks++;
      if (state !== 4'(s[i])) begin
        errors++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, state, s[i]);
      end
      if (i == 3) begin
        checks++;
        if ({reg_write, pc_write, pc_source, alu_src_b} !== 5'b11001) begin
          errors++; $display("FAIL rtype_wb got %b want 11001", {reg_write, pc_write, pc_source, alu_src_b});
        end
      end else if (i < 3) begin
        checks++;
        if ({reg_write, pc_write} !== 2'b00) begin
          errors++; $display("FAIL rtype_early[%0d] got %b want 00", i, {reg_write, pc_write});
        end
      end
      if (i < s.size() - 1) @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    int s[$] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    int r[$] = '{1, 0, 1, 0, 0, 0, 1, 0, 1};
    opcode = OP_LOAD;
    foreach (s[i]) begin
      mem_ready = r[i][0];
      #1;
      checks++;
      if (state !== 4'(s[i])) begin
        errors++; $display("FAIL load_state[%0d] got %0d want %0d", i, state, s[i]);
      end
      if (s[i] == 3) begin
        checks++;
        if ({mem_read, i_or_d, mdr_write} !== {2'b11, r[i][0]}) begin
          errors++; $display("FAIL load_mem[%0d] got %b want %b", i, {mem_read, i_or_d, mdr_write}, {2'b11, r[i][0]});
        end
      end
      if (s[i] == 4) begin
        checks++;
        if (wb_sel !== 2'b01 || reg_write !== 1'b1 || mdr_write !== 1'b0) begin
          errors++; $display("FAIL load_wb got wb_sel=%b rw=%b mdr=%b want 01/1/0", wb_sel, reg_write, mdr_write);
        end
      end
      if (i < s.size() - 1) @(negedge clk);
    end
  endtask

  task automatic test_branch();
    int s1[$] = '{0, 1, 5, 0};
    int s0[$] = '{0, 1, 5, 7, 0};
    opcode = OP_BR; mem_ready = 1'b1; alu_bcond = 1'b1;
    foreach (s1[i]) begin
      #1;
      checks++;
      if (state !== 4'(s1[i])) begin
        errors++; $display("FAIL br_taken_state[%0d] got %0d want %0d", i, state, s1[i]);
      end
      if (i == 2) begin
        checks++;
        if ({pc_write, pc_source, alu_op_sel} !== 4'b1101) begin
          errors++; $display("FAIL br_taken_pc got %b want 1101", {pc_write, pc_source, alu_op_sel});
        end
      end
      if (i < s1.size() - 1) @(negedge clk);
    end
    alu_bcond = 1'b0;
    foreach (s0[i]) begin
      #1;
      checks++;
      if (state !== 4'(s0[i])) begin
        errors++; $display("FAIL br_not_state[%0d] got %0d want %0d", i, state, s0[i]);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if ({pc_write, pc_source} !== ((i == 3) ? 2'b10 : 2'b00)) begin
          errors++; $display("FAIL br_not_pc[%0d] got %b", i, {pc_write, pc_source});
        end
      end
      if (i < s0.size() - 1) @(negedge clk);
    end
  endtask

  task automatic test_jumps();
    int sj[$] = '{0, 1, 6, 0};
    int sr[$] = '{0, 1, 2, 6, 0};
    opcode = OP_JAL; mem_ready = 1'b1;
    foreach (sj[i]) begin
      #1;
      checks++;
      if (state !== 4'(sj[i])) begin
        errors++; $display("FAIL jal_state[%0d] got %0d want %0d", i, state, sj[i]);
      end
      if (i == 2) begin
        checks++;
        if ({reg_write, wb_sel, pc_write, pc_source} !== 5'b11011) begin
          errors++; $display("FAIL jal_jmp got %b want 11011", {reg_write, wb_sel, pc_write, pc_source});
        end
      end
      if (i < sj.size() - 1) @(negedge clk);
    end
    opcode = OP_JALR;
    foreach (sr[i]) begin
      #1;
      checks++;
      if (state !== 4'(sr[i])) begin
        errors++; $display("FAIL jalr_state[%0d] got %0d want %0d", i, state, sr[i]);
      end
      if (i < sr.size() - 1) @(negedge clk);
    end
  endtask

  task automatic test_ecall();
    opcode = OP_SYS; mem_ready = 1'b1; halt_req = 1'b0;
    #1;
    @(negedge clk); #1;
    checks++;
    if ({state, is_ecall, pc_write, pc_source, alu_src_b} !== {4'd1, 5'b11001}) begin
      errors++; $display("FAIL ecall_cont_id got st=%0d %b want 1/11001", state, {is_ecall, pc_write, pc_source, alu_src_b});
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL ecall_cont_ret got %0d want 0", state);
    end
    halt_req = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd1 || is_ecall !== 1'b1 || pc_write !== 1'b0) begin
      errors++; $display("FAIL ecall_halt_id got st=%0d ecall=%b pcw=%b want 1/1/0", state, is_ecall, pc_write);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      halt_req  = 1'($urandom_range(0, 1));
      opcode    = 7'($urandom);
      #1;
      checks++;
      if (state !== 4'd8 || is_halted !== 1'b1 ||
          {pc_write, ir_write, mem_read, mem_write, reg_write, mdr_write} !== 6'b0) begin
        errors++; $display("FAIL halt_hold[%0d] got st=%0d halted=%b", i, state, is_halted);
      end
    end
    halt_req = 1'b0;
    apply_reset();
    #1;
    checks++;
    if (state !== 4'd0 || is_halted !== 1'b0) begin
      errors++; $display("FAIL halt_exit got st=%0d halted=%b want 0/0", state, is_halted);
    end
  endtask

  task automatic test_reset_mid_mem();
    int s[$] = '{0, 1, 2, 3, 3};
    int r[$] = '{1, 1, 1, 0, 0};
    opcode = OP_STORE;
    foreach (s[i]) begin
      mem_ready = r[i][0];
      #1;
      checks++;
      if (state !== 4'(s[i])) begin
        errors++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, s[i]);
      end
      if (i < s.size() - 1) @(negedge clk);
    end
    checks++;
    if ({mem_write, mem_read, i_or_d} !== 3'b101) begin
      errors++; $display("FAIL sw_mem got %b want 101", {mem_write, mem_read, i_or_d});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || state !== 4'd0) begin
      errors++; $display("FAIL sw_reset got mw=%b mr=%b st=%0d want 0/0/0", mem_write, mem_read, state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference: per-class state path built from the instruction-flow rules.
  task automatic test_random();
    int exp_s[$];
    int rdy[$];
    int cls, ifw, mw, bcond, writes_rd, n_ir, n_mdr, n_memw, last;
    logic [6:0] op;
    for (int n = 0; n < 60; n++) begin
      cls = int'($urandom_range(0, 8));
      bcond = int'($urandom_range(0, 1));
      ifw = int'($urandom_range(0, 3));
      mw  = int'($urandom_range(0, 3));
      exp_s.delete(); rdy.delete();
      repeat (ifw) begin exp_s.push_back(0); rdy.push_back(0); end
      exp_s.push_back(0); rdy.push_back(1);
      exp_s.push_back(1); rdy.push_back(int'($urandom_range(0, 1)));
      case (cls)
        0, 1: begin
          op = (cls == 0) ? OP_R : OP_I;
          exp_s.push_back(2); exp_s.push_back(4);
          rdy.push_back(int'($urandom_range(0, 1))); rdy.push_back(int'($urandom_range(0, 1)));
        end
        2, 3: begin
          op = (cls == 2) ? OP_LOAD : OP_STORE;
          exp_s.push_back(2); rdy.push_back(int'($urandom_range(0, 1)));
          repeat (mw) begin exp_s.push_back(3); rdy.push_back(0); end
          exp_s.push_back(3); rdy.push_back(1);
          if (cls == 2) begin exp_s.push_back(4); rdy.push_back(int'($urandom_range(0, 1))); end
        end
        4: begin
          op = OP_BR;
          exp_s.push_back(5); rdy.push_back(int'($urandom_range(0, 1)));
          if (bcond == 0) begin exp_s.push_back(7); rdy.push_back(int'($urandom_range(0, 1))); end
        end
        5: begin op = OP_JAL; exp_s.push_back(6); rdy.push_back(int'($urandom_range(0, 1))); end
        6: begin
          op = OP_JALR;
          exp_s.push_back(2); exp_s.push_back(6);
          rdy.push_back(int'($urandom_range(0, 1))); rdy.push_back(int'($urandom_range(0, 1)));
        end
        7: op = OP_SYS;
        default: begin op = OP_LUI; exp_s.push_back(7); rdy.push_back(int'($urandom_range(0, 1))); end
      endcase
      writes_rd = (cls <= 2 || cls == 5 || cls == 6) ? 1 : 0;
      last = exp_s.size() - 1;
      n_ir = 0; n_mdr = 0; n_memw = 0;
      foreach (exp_s[i]) begin
        opcode    = op;
        mem_ready = rdy[i][0];
        alu_bcond = (exp_s[i] == 5) ? bcond[0] : 1'($urandom_range(0, 1));
        halt_req  = (cls == 7) ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (state !== 4'(exp_s[i]) || pc_write !== (i == last) ||
            reg_write !== (i == last && writes_rd == 1) || mem_timeout !== 1'b0) begin
          errors++;
          $display("FAIL rand[%0d] cls=%0d cyc=%0d got st=%0d pcw=%b rw=%b to=%b want st=%0d",
                   n, cls, i, state, pc_write, reg_write, mem_timeout, exp_s[i]);
        end
        n_ir += int'(ir_write); n_mdr += int'(mdr_write); n_memw += int'(mem_write);
        @(negedge clk);
      end
      #1;
      checks++;
      if (state !== 4'd0 || n_ir != 1 || n_mdr != ((cls == 2) ? 1 : 0) ||
          n_memw != ((cls == 3) ? mw + 1 : 0)) begin
        errors++;
        $display("FAIL rand_counts[%0d] cls=%0d got st=%0d ir=%0d mdr=%0d memw=%0d", n, cls, state, n_ir, n_mdr, n_memw);
      end
    end
  endtask

`ifdef MC_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int s[$] = '{0, 0, 0, 0, 8, 8};
    apply_reset();
    mem_ready = 1'b0; opcode = OP_R;
    foreach (s[i]) begin
      #1;
      checks++;
      if (state !== 4'(s[i]) || mem_timeout !== (s[i] == 8)) begin
        errors++; $display("FAIL timeout[%0d] got st=%0d to=%b want %0d", i, state, mem_timeout, s[i]);
      end
      if (i < s.size() - 1) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_timeout !== 1'b0 || state !== 4'd0) begin
      errors++; $display("FAIL timeout_clear got to=%b st=%0d want 0/0", mem_timeout, state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_jumps();
    test_ecall();
    test_reset_mid_mem();
    test_random();
`ifdef MC_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
